// File: rtl/vga_sink_monitor.sv
// vga_sink_monitor: receive-side VGA timing checker and frame statistics.
// Samples hsync/vsync/RGB on pix_en ticks, measures line length, hsync
// width, lines per frame and vsync width, checks them against the
// parameters, declares lock after one clean frame and reports per-frame
// red/green/blue high-tick counts.
// Ports: clk, rst (sync, active-high), pix_en, vga_h_sync, vga_v_sync,
//   vga_R/G/B in; locked, frame_done, err_pulse, err_code[3:0],
//   err_count[7:0], line_len[11:0], frame_lines[11:0], r/g/b_count[18:0],
//   frame_crc[15:0] out.
// Optional: define VGA_SINK_CRC_EN to build a per-frame CRC-16-CCITT over
//   {R,G,B}; without it frame_crc is tied to zero.
module vga_sink_monitor #(
    parameter int   H_TOTAL  = 800,
    parameter int   H_SYNC   = 96,
    parameter int   V_TOTAL  = 525,
    parameter int   V_SYNC   = 2,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic        vga_R,
    input  logic        vga_G,
    input  logic        vga_B,
    output logic        locked,
    output logic        frame_done,
    output logic        err_pulse,
    output logic [3:0]  err_code,
    output logic [7:0]  err_count,
    output logic [11:0] line_len,
    output logic [11:0] frame_lines,
    output logic [18:0] r_count,
    output logic [18:0] g_count,
    output logic [18:0] b_count,
    output logic [15:0] frame_crc
);

    typedef enum logic [1:0] {ACQUIRE, MEASURE, LOCKED} state_t;

    state_t      state, state_next;
    logic        frame_bad, frame_bad_next;
    logic        h_seen, h_seen_next;
    logic        done_next;
    logic        h_prev, v_prev;
    logic [11:0] h_cnt, l_cnt;
    logic [18:0] acc_r, acc_g, acc_b;

    // Syncs normalised to "asserted" regardless of polarity.
    logic h_a, v_a;
    assign h_a = (vga_h_sync == SYNC_POL);
    assign v_a = (vga_v_sync == SYNC_POL);

    logic h_lead, h_trail, v_lead, v_trail;
    assign h_lead  = pix_en & h_a & ~h_prev;
    assign h_trail = pix_en & ~h_a & h_prev;
    assign v_lead  = pix_en & v_a & ~v_prev;
    assign v_trail = pix_en & ~v_a & v_prev;

    // Widths use the pre-increment counters: the trailing tick is the
    // first deasserted one, so the count equals the asserted span.
    logic       checking;
    logic [3:0] err_vec;
    logic       any_err;
    assign checking   = (state != ACQUIRE);
    assign err_vec[0] = checking & h_lead & h_seen & (h_cnt != 12'(H_TOTAL));
    assign err_vec[1] = checking & h_trail & (h_cnt != 12'(H_SYNC));
    assign err_vec[2] = checking & v_lead & (l_cnt != 12'(V_TOTAL));
    assign err_vec[3] = checking & v_trail & (l_cnt != 12'(V_SYNC));
    assign any_err    = |err_vec;

    always_comb begin
        state_next     = state;
        frame_bad_next = frame_bad;
        h_seen_next    = h_seen;
        done_next      = 1'b0;
        unique case (state)
            ACQUIRE: begin
                // h_seen stays clear even on a coincident hsync edge so the
                // first measured line is a complete one.
                if (v_lead) begin
                    state_next     = MEASURE;
                    frame_bad_next = 1'b0;
                    h_seen_next    = 1'b0;
                end
            end
            MEASURE: begin
                if (h_lead)  h_seen_next    = 1'b1;
                if (any_err) frame_bad_next = 1'b1;
                if (v_lead) begin
                    done_next = 1'b1;
                    if (!frame_bad && !any_err) state_next = LOCKED;
                    else frame_bad_next = 1'b0;
                end
            end
            LOCKED: begin
                if (h_lead)  h_seen_next = 1'b1;
                if (v_lead)  done_next   = 1'b1;
                if (any_err) state_next  = ACQUIRE;
            end
            default: state_next = ACQUIRE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACQUIRE;
            frame_bad   <= 1'b0;
            h_seen      <= 1'b0;
            locked      <= 1'b0;
            frame_done  <= 1'b0;
            err_pulse   <= 1'b0;
            err_code    <= '0;
            err_count   <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            r_count     <= '0;
            g_count     <= '0;
            b_count     <= '0;
            h_prev      <= 1'b0;
            v_prev      <= 1'b0;
            h_cnt       <= '0;
            l_cnt       <= '0;
            acc_r       <= '0;
            acc_g       <= '0;
            acc_b       <= '0;
        end else begin
            state      <= state_next;
            frame_bad  <= frame_bad_next;
            h_seen     <= h_seen_next;
            frame_done <= done_next;
            err_pulse  <= any_err;
            // Follows the state register, so it lags the pulses by a cycle.
            locked     <= (state == LOCKED);
            if (any_err) begin
                err_code <= err_vec;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            if (pix_en) begin
                h_prev <= h_a;
                v_prev <= v_a;
                if (h_lead) begin
                    line_len <= h_cnt;
                    h_cnt    <= 12'd1;
                end else if (h_cnt != 12'hFFF) begin
                    h_cnt <= h_cnt + 12'd1;
                end
                if (v_lead) begin
                    frame_lines <= l_cnt;
                    l_cnt       <= h_lead ? 12'd1 : 12'd0;
                    r_count     <= acc_r;
                    g_count     <= acc_g;
                    b_count     <= acc_b;
                    acc_r       <= 19'(vga_R);
                    acc_g       <= 19'(vga_G);
                    acc_b       <= 19'(vga_B);
                end else begin
                    if (h_lead && l_cnt != 12'hFFF) l_cnt <= l_cnt + 12'd1;
                    acc_r <= acc_r + 19'(vga_R);
                    acc_g <= acc_g + 19'(vga_G);
                    acc_b <= acc_b + 19'(vga_B);
                end
            end
        end
    end

`ifdef VGA_SINK_CRC_EN
    // CRC-16-CCITT, poly 0x1021, shifting R then G then B.
    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [2:0]  d);
        logic [15:0] x;
        x = c;
        for (int i = 2; i >= 0; i--) begin
            if (x[15] ^ d[i]) x = {x[14:0], 1'b0} ^ 16'h1021;
            else              x = {x[14:0], 1'b0};
        end
        return x;
    endfunction

    logic [15:0] crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            crc       <= 16'hFFFF;
            frame_crc <= '0;
        end else if (pix_en) begin
            if (v_lead) begin
                frame_crc <= crc;
                crc       <= crc_step(16'hFFFF, {vga_R, vga_G, vga_B});
            end else begin
                crc <= crc_step(crc, {vga_R, vga_G, vga_B});
            end
        end
    end
`else
    assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_sink_monitor.sv
// tb_vga_sink_monitor: directed frames with a scoreboard of expected
// frame_done / err_pulse results, using a small 40x12 raster.
module tb_vga_sink_monitor;

    localparam int   HT = 40;
    localparam int   HS = 6;
    localparam int   VT = 12;
    localparam int   VS = 2;
    localparam logic SP = 1'b0;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic        vga_h_sync;
    logic        vga_v_sync;
    logic        vga_R;
    logic        vga_G;
    logic        vga_B;
    logic        locked;
    logic        frame_done;
    logic        err_pulse;
    logic [3:0]  err_code;
    logic [7:0]  err_count;
    logic [11:0] line_len;
    logic [11:0] frame_lines;
    logic [18:0] r_count;
    logic [18:0] g_count;
    logic [18:0] b_count;
    logic [15:0] frame_crc;

    vga_sink_monitor #(
        .H_TOTAL (HT),
        .H_SYNC  (HS),
        .V_TOTAL (VT),
        .V_SYNC  (VS),
        .SYNC_POL(SP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .vga_h_sync (vga_h_sync),
        .vga_v_sync (vga_v_sync),
        .vga_R      (vga_R),
        .vga_G      (vga_G),
        .vga_B      (vga_B),
        .locked     (locked),
        .frame_done (frame_done),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .err_count  (err_count),
        .line_len   (line_len),
        .frame_lines(frame_lines),
        .r_count    (r_count),
        .g_count    (g_count),
        .b_count    (b_count),
        .frame_crc  (frame_crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ll;
        int fl;
        int r;
        int g;
        int b;
        int ec;
        int lk;
        bit crc_eq;
    } fexp_t;

    typedef struct {
        logic [3:0] code;
        int         cnt;
    } eexp_t;

    fexp_t fq[$];
    eexp_t eq[$];

    int checks   = 0;
    int failures = 0;
    int last_pat = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // One pix_en tick: strobe high for one clock, low for the next.
    task automatic tick(bit h, bit v, bit r, bit g, bit b);
        vga_h_sync = h ? SP : ~SP;
        vga_v_sync = v ? SP : ~SP;
        vga_R      = r;
        vga_G      = g;
        vga_B      = b;
        pix_en     = 1'b1;
        @(posedge clk);
        #1 pix_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // pat bit0: R ticks 8..31, bit1: G ticks 32..33, bit2: B ticks 0..2.
    task automatic send_line(int len, int hsw, bit vs, int pat);
        for (int t = 0; t < len; t++)
            tick(t < hsw, vs,
                 pat[0] && t >= 8 && t <= 31,
                 pat[1] && (t == 32 || t == 33),
                 pat[2] && t <= 2);
    endtask

    // close_lk >= 0 means the vsync edge opening this frame is expected to
    // close the previous one with a frame_done, then locked == close_lk.
    task automatic send_frame(int nlines, int pat, int bad_len, int bad_hs,
                              int close_lk, int close_ec, bit crc_eq);
        fexp_t e;
        if (close_lk >= 0) begin
            e.ll     = HT;
            e.fl     = VT;
            e.r      = last_pat[0] ? 24 * VT : 0;
            e.g      = last_pat[1] ? 2 * VT : 0;
            e.b      = last_pat[2] ? 3 * VT : 0;
            e.ec     = close_ec;
            e.lk     = close_lk;
            e.crc_eq = crc_eq;
            fq.push_back(e);
        end
        for (int l = 0; l < nlines; l++)
            send_line(l == bad_len ? HT + 1 : HT,
                      l == bad_hs ? HS - 1 : HS,
                      l < VS, pat);
        last_pat = pat;
    endtask

    task automatic push_err(logic [3:0] code, int cnt);
        eexp_t e;
        e.code = code;
        e.cnt  = cnt;
        eq.push_back(e);
    endtask

    task automatic reset_and_check(string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_locked"},      locked, 0);
        check({tag, "_frame_done"},  frame_done, 0);
        check({tag, "_err_pulse"},   err_pulse, 0);
        check({tag, "_err_code"},    err_code, 0);
        check({tag, "_err_count"},   err_count, 0);
        check({tag, "_line_len"},    line_len, 0);
        check({tag, "_frame_lines"}, frame_lines, 0);
        check({tag, "_r_count"},     r_count, 0);
        check({tag, "_g_count"},     g_count, 0);
        check({tag, "_b_count"},     b_count, 0);
        check({tag, "_frame_crc"},   frame_crc, 0);
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses an output.
    initial begin
        int          lk_f;
        bit          lk_e;
        logic [15:0] last_crc;
        fexp_t       f;
        eexp_t       e;
        lk_f     = -1;
        lk_e     = 1'b0;
        last_crc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lk_f = -1;
                lk_e = 1'b0;
            end else begin
                if (lk_f >= 0) check("locked_after_frame", locked, lk_f);
                lk_f = -1;
                if (lk_e) check("locked_after_err", locked, 0);
                lk_e = 1'b0;
                if (frame_done) begin
                    if (fq.size() == 0) begin
                        check("unexpected_frame_done", 1, 0);
                    end else begin
                        f = fq.pop_front();
                        check("fd_line_len",    line_len, f.ll);
                        check("fd_frame_lines", frame_lines, f.fl);
                        check("fd_r_count",     r_count, f.r);
                        check("fd_g_count",     g_count, f.g);
                        check("fd_b_count",     b_count, f.b);
                        check("fd_err_count",   err_count, f.ec);
`ifdef VGA_SINK_CRC_EN
                        if (f.crc_eq) begin
                            check("crc_repeat", frame_crc, last_crc);
                            check("crc_nonzero", frame_crc != 0, 1);
                        end
                        last_crc = frame_crc;
`else
                        check("crc_off", frame_crc, 0);
`endif
                        lk_f = f.lk;
                    end
                end
                if (err_pulse) begin
                    if (eq.size() == 0) begin
                        check("unexpected_err_pulse", 1, 0);
                    end else begin
                        e = eq.pop_front();
                        check("err_code",  err_code, e.code);
                        check("err_count", err_count, e.cnt);
                        lk_e = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        pix_en     = 1'b0;
        vga_h_sync = ~SP;
        vga_v_sync = ~SP;
        vga_R      = 1'b0;
        vga_G      = 1'b0;
        vga_B      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_and_check("rst0");

        // Clean frames: lock at the second vsync edge.
        send_frame(VT, 1, -1, -1, -1, 0, 0);
        send_frame(VT, 1, -1, -1, 1, 0, 0);
        // Locked: 41-tick line on line 4 drops lock.
        push_err(4'b0001, 1);
        send_frame(VT, 7, 4, -1, 1, 0, 1);
        send_frame(VT, 2, -1, -1, -1, 0, 0);
        send_frame(3, 1, -1, -1, 1, 1, 0);

        // Mid-frame reset while locked.
        reset_and_check("rst1");
        send_frame(VT, 4, -1, -1, -1, 0, 0);
        send_frame(2, 1, -1, -1, 1, 0, 0);
        reset_and_check("rst2");

        // Short hsync in the measuring frame blocks lock for one frame.
        push_err(4'b0010, 1);
        send_frame(VT, 1, -1, 3, -1, 0, 0);
        send_frame(VT, 1, -1, -1, 0, 1, 0);
        send_frame(1, 1, -1, -1, 1, 1, 1);
        reset_and_check("rst3");

        // 300 consecutive 41-tick lines in MEASURE saturate the counter.
        for (int k = 1; k <= 300; k++) push_err(4'b0001, k > 255 ? 255 : k);
        send_line(HT, HS, 1'b1, 0);
        send_line(HT, HS, 1'b1, 0);
        for (int k = 0; k < 300; k++) send_line(HT + 1, HS, 1'b0, 0);
        send_line(HT, HS, 1'b0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("sat_err_count", err_count, 255);
        check("sat_locked", locked, 0);
        check("frame_queue_empty", fq.size(), 0);
        check("err_queue_empty", eq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sink_monitor.md
Name: vga_sink_monitor

Overview:
- Receive-side counterpart of the `super` VGA output (`vga_h_sync`, `vga_v_sync`, `vga_R`/`vga_G`/`vga_B`).
- Samples the five VGA wires on a pixel-enable strobe and measures line length, hsync width, lines per frame and vsync width.
- Checks those measurements against parameterised timing and declares lock after one clean frame.
- Reports per-frame colour pixel counts so benches and on-chip self-test can check frames the miner display produces.

Parameters:
H_TOTAL, 800, pixel ticks per line
H_SYNC, 96, hsync asserted width in ticks
V_TOTAL, 525, lines per frame
V_SYNC, 2, vsync asserted width in lines
SYNC_POL, 0, asserted level of both syncs (0 = active-low)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
pix_en  in  1  pixel strobe; all sampling/counting only on cycles with pix_en=1
vga_h_sync  in  1  horizontal sync from source
vga_v_sync  in  1  vertical sync from source
vga_R  in  1  red
vga_G  in  1  green
vga_B  in  1  blue
locked  out  1  timing locked
frame_done  out  1  one-cycle pulse, frame results valid
err_pulse  out  1  one-cycle pulse on any timing error
err_code  out  4  {vsync width, frame lines, hsync width, line len} mismatch bits, held until next error
err_count  out  8  saturating error-pulse count
line_len  out  12  last measured line length (ticks)
frame_lines  out  12  last measured lines/frame
r_count  out  19  red-high ticks in last frame
g_count  out  19  green-high ticks in last frame
b_count  out  19  blue-high ticks in last frame
frame_crc  out  16  see Optional Feature

Behaviour:
- Reset: all outputs 0; state ACQUIRE; all counters and edge-history registers 0; h_seen=0.
- Sync normalisation: each sync is internally "asserted" when it equals SYNC_POL.
- Edge detection: previous sampled values are registered on pix_en ticks. A leading edge is a deasserted-to-asserted transition; a trailing edge is the reverse.
- h_cnt:
  - Leading hsync edge: line_len <= h_cnt, then h_cnt <= 1.
  - Other ticks: h_cnt += 1, saturating at 4095.
  - Period 800 therefore gives line_len = 800.
- hsync width: on a trailing hsync edge, width = h_cnt (pre-increment). A 96-tick pulse gives 96.
- l_cnt:
  - Increments on each hsync leading edge.
  - On a vsync leading edge: frame_lines <= l_cnt, then l_cnt <= (hsync leading edge this tick) ? 1 : 0.
- vsync width: on a vsync trailing edge, width = l_cnt (pre-increment).
- Colour accumulators:
  - Add 1 per tick where the colour is high, with no blanking qualification.
  - On a vsync leading edge: r/g/b_count latch the accumulated value; accumulators restart with the current tick's contribution.
- Checks: active only in MEASURE/LOCKED.
  - Line length check requires h_seen; h_seen is set at the first hsync leading edge after entering MEASURE.
  - Mismatch sets the matching err_code bit(s), pulses err_pulse one cycle later, and increments err_count (saturates at 255).
- FSM:
  - ACQUIRE: on vsync leading edge -> MEASURE (clears frame_bad and h_seen).
  - MEASURE:
    - Any error sets frame_bad.
    - On vsync leading edge, pulse frame_done.
    - If !frame_bad and no error this tick -> LOCKED.
    - Else stay in MEASURE and clear frame_bad.
  - LOCKED:
    - frame_done pulses on each vsync leading edge.
    - Any error -> ACQUIRE.
  - locked = (state == LOCKED), registered; it drops the cycle after the error pulse.
- Latency: measurement registers and pulses are valid the clk cycle after the sampling pix_en tick.
- Simultaneous events:
  - An error on the same tick as a vsync edge in MEASURE counts against the closing frame.
  - Coincident h/v leading edges are legal.
- rst mid-frame returns to the reset state immediately; the next lock needs two vsync leading edges.

Optional Feature:
VGA_SINK_CRC_EN:
- Defined: a CRC-16-CCITT (poly 0x1021, init 0xFFFF) is updated per pix_en tick over the 3-bit RGB value {R,G,B}, MSB first. It is latched to frame_crc and re-initialised on each vsync leading edge.
- Undefined: frame_crc is constant 0 and no CRC logic is built.

Test Plan:
- Ideal 800x525 timing, hsync 96, vsync 2 lines, pix_en every 2nd clk -> locked rises one cycle after the 2nd vsync leading edge; line_len=800, frame_lines=525, err_count=0.
- Locked source with R high for ticks 144..783 of every line, G/B low -> each frame_done shows r_count=336000, g_count=0, b_count=0.
- One 801-tick line injected while locked -> err_code=0001, err_pulse one cycle, err_count=1, locked=0, FSM to ACQUIRE; relock after two further clean vsync edges.
- hsync width 95 in MEASURE frame -> err_code=0010, no lock at that frame's end; lock at the following frame's end.
- rst asserted mid-frame while locked -> next cycle all outputs 0; relock only after two vsync leading edges.
- 300 consecutive bad lines -> err_count saturates at 255. With VGA_SINK_CRC_EN, two identical frames give identical nonzero frame_crc.
